// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divider.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  // System clocks per serial bit, truncated; the transmitter uses the same divider.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on the system clock: mid-bit start validation and sampling,
// one-cycle done / framing-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      donerx,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int clkcount  = baud_div(clk_freq, baud_rate);
  localparam int halfcount = clkcount / 2;
  localparam int cnt_w     = $clog2(clkcount);
  localparam int idx_w     = $clog2(UART_DATA_BITS);

  if (clkcount < 4) begin : g_bad_baud
    $error("uart_rx: clk_freq/baud_rate must be at least 4");
  end

  localparam logic [cnt_w-1:0] half_last = cnt_w'(halfcount - 1);
  localparam logic [cnt_w-1:0] bit_last  = cnt_w'(clkcount - 1);
  localparam logic [idx_w-1:0] idx_last  = idx_w'(UART_DATA_BITS - 1);

  uart_rx_state_t            state;
  logic [cnt_w-1:0]          cnt;
  logic [idx_w-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      rx_s, rx_s_d;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      donerx    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      rx_s_d    <= 1'b1;
    end else begin
      rx_s_d    <= rx_s;
      donerx    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        // Edge-triggered so a line held low (break, bad stop) cannot restart a frame.
        IDLE: if (rx_s_d && !rx_s) begin
          state <= START;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        START: if (cnt == half_last) begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) begin
            state <= DATA;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        DATA: if (cnt == bit_last) begin
          cnt            <= '0;
          shift[bit_idx] <= rx_s;
          bit_idx        <= bit_idx + 1'b1;
          if (bit_idx == idx_last) state <= STOP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // Back to IDLE right at the stop sample so a back-to-back start edge is caught.
        STOP: if (cnt == bit_last) begin
          cnt   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
          if (rx_s) begin
            rx_data <= shift;
            donerx  <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at default parameters (104 clk per bit).
module tb_uart_rx;

  localparam int BIT = 104;
  localparam int LAT = 3 + 52 + 9 * 104; // line start edge -> pulse visible

  typedef struct packed {
    logic        kind; // 0 = good byte, 1 = framing error
    logic [7:0]  data;
    logic [31:0] cyc;
  } evt_t;

  logic       clk, rst, rx;
  logic [7:0] rx_data;
  logic       donerx, frame_err, busy;

  int total = 0;
  int bad = 0;
  int both_cnt = 0;
  logic [31:0] cyc = 0;
  logic [7:0]  last_good = 8'h00;
  evt_t exp_q[$];
  evt_t obs_q[$];

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .donerx    (donerx),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (donerx && frame_err) both_cnt++;
    if (donerx) obs_q.push_back('{kind: 1'b0, data: rx_data, cyc: cyc});
    if (frame_err) obs_q.push_back('{kind: 1'b1, data: 8'h00, cyc: cyc});
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  // Drives one frame starting at a negedge and records what the receiver must report.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    if (stop) begin
      exp_q.push_back('{kind: 1'b0, data: d, cyc: cyc + LAT});
      last_good = d;
    end else begin
      exp_q.push_back('{kind: 1'b1, data: 8'h00, cyc: cyc + LAT});
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    int busy_seen;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (rx_data !== 8'h00 || donerx !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h done=%b ferr=%b busy=%b want 00 0 0 0",
               rx_data, donerx, frame_err, busy);
    end
    busy_seen = 0;
    repeat (2000) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    total++;
    if (busy_seen !== 0 || obs_q.size() !== 0) begin
      bad++;
      $display("FAIL reset_idle: got busy_cycles=%0d events=%0d want 0 0", busy_seen, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_single;
    evt_t e, o;
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL single_missing: got no event want kind=%0d data=%h cyc=%0d", e.kind, e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL single_evt: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    total++;
    if (obs_q.size() !== 0 || rx_data !== 8'hA5) begin
      bad++;
      $display("FAIL single_final: got extra=%0d data=%h want 0 a5", obs_q.size(), rx_data);
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    evt_t e, o;
    logic [31:0] prev_cyc;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_bit(1'b1);
    prev_cyc = 0;
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL b2b_missing: got no event want data=%h cyc=%0d", e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e || (n == 1 && o.cyc - prev_cyc !== 32'd1040)) begin
          bad++;
          $display("FAIL b2b_evt: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d (gap 1040)",
                   o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end
        prev_cyc = o.cyc;
      end
    end
    total++;
    if (obs_q.size() !== 0 || rx_data !== 8'hFF) begin
      bad++;
      $display("FAIL b2b_final: got extra=%0d data=%h want 0 ff", obs_q.size(), rx_data);
    end
    obs_q.delete();
  endtask

  task automatic test_glitch;
    int busy_cnt;
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 20) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    total++;
    if (busy_cnt < 50 || busy_cnt > 54) begin
      bad++;
      $display("FAIL glitch_busy: got busy_cycles=%0d want 50..54", busy_cnt);
    end
    total++;
    if (obs_q.size() !== 0 || busy !== 1'b0 || rx_data !== last_good) begin
      bad++;
      $display("FAIL glitch_quiet: got events=%0d busy=%b data=%h want 0 0 %h",
               obs_q.size(), busy, rx_data, last_good);
    end
    obs_q.delete();
  endtask

  task automatic test_frame_err;
    evt_t e, o;
    logic [7:0] prev_good;
    int busy_cnt;
    prev_good = last_good;
    send_frame(8'h3C, 1'b0);
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i >= 100 && busy) busy_cnt++;
    end
    e = exp_q.pop_front();
    total++;
    if (obs_q.size() !== 1) begin
      bad++;
      $display("FAIL ferr_count: got events=%0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        bad++;
        $display("FAIL ferr_evt: got kind=%0d cyc=%0d want kind=%0d cyc=%0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    total++;
    if (rx_data !== prev_good || busy_cnt !== 0) begin
      bad++;
      $display("FAIL ferr_hold: got data=%h busy_while_low=%0d want %h 0", rx_data, busy_cnt, prev_good);
    end
    obs_q.delete();
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1);
    e = exp_q.pop_front();
    total++;
    if (obs_q.size() !== 1) begin
      bad++;
      $display("FAIL after_ferr_count: got events=%0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      if (o !== e || rx_data !== 8'h81) begin
        bad++;
        $display("FAIL after_ferr_evt: got data=%h cyc=%0d rx_data=%h want data=%h cyc=%0d",
                 o.data, o.cyc, rx_data, e.data, e.cyc);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_midframe;
    evt_t e, o;
    logic [7:0] d;
    d = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (rx_data !== 8'h00 || donerx !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got data=%h done=%b ferr=%b busy=%b want 00 0 0 0",
               rx_data, donerx, frame_err, busy);
    end
    rx = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (BIT * 10) @(negedge clk);
    total++;
    if (obs_q.size() !== 0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL midreset_quiet: got events=%0d data=%h want 0 00", obs_q.size(), rx_data);
    end
    obs_q.delete();
    send_frame(8'h55, 1'b1);
    drive_bit(1'b1);
    e = exp_q.pop_front();
    total++;
    if (obs_q.size() !== 1) begin
      bad++;
      $display("FAIL midreset_rx_count: got events=%0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      if (o !== e || rx_data !== 8'h55) begin
        bad++;
        $display("FAIL midreset_rx_evt: got data=%h cyc=%0d rx_data=%h want data=%h cyc=%0d",
                 o.data, o.cyc, rx_data, e.data, e.cyc);
      end
    end
    obs_q.delete();
    total++;
    if (both_cnt !== 0) begin
      bad++;
      $display("FAIL pulse_overlap: got cycles=%0d want 0", both_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Pairs with the team's existing UART transmitter. It runs on the system clock with an internal baud counter; there is no derived clock.
- Synchronises the asynchronous serial line, validates the start bit at mid-bit, and samples each data bit at mid-bit.
- Presents the received byte with a one-cycle done pulse, or flags a framing error.

Parameters:
- clk_freq, 1000000, system clock frequency in Hz.
- baud_rate, 9600, line rate in bits/s.
- Derived localparam clkcount = clk_freq/baud_rate (integer division; 104 at defaults).
- Derived localparam halfcount = clkcount/2 (52 at defaults).
- Legal only if clkcount >= 4; elaboration error otherwise.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  last correctly framed byte; held until the next good frame.
- donerx  output  1  one-cycle pulse: rx_data updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; frame discarded.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rx_data=8'h00, donerx=0, frame_err=0, busy=0, counters=0, sync flops=1.
- Sync: rx passes through 2 flops to give rx_s. rx_s_d is a further delay used for edge detection. All decisions use rx_s/rx_s_d only.
- IDLE:
  - Enter START on a falling edge (rx_s_d=1, rx_s=0); clear the baud counter.
  - A line stuck low (break, or after a framing error) does not re-trigger until it returns high.
- START:
  - Count halfcount cycles, then sample rx_s.
  - Sampled 0: enter DATA, clear counter and bit index.
  - Sampled 1: glitch; return to IDLE with no pulse.
- DATA:
  - Every clkcount cycles sample rx_s into shift[bit index], LSB first, and increment the index.
  - After the 8th sample enter STOP with the counter cleared.
- STOP:
  - After clkcount cycles sample rx_s.
  - Sampled 1: rx_data <= shift and donerx=1 for exactly one cycle.
  - Sampled 0: frame_err=1 for one cycle; rx_data unchanged.
  - Either way return to IDLE.
- Timing: let t0 be the clk edge where the falling edge is detected.
  - Start sample at t0+halfcount.
  - Data bit i sample at t0+halfcount+(i+1)*clkcount.
  - Stop sample at t0+halfcount+9*clkcount. donerx/frame_err are registered there and visible in the following cycle.
  - Input-to-t0 latency is 3 clk.
- Back-to-back frames: the start edge of the next frame, arriving half a bit after the stop sample, must be caught. The block returns to IDLE within 1 cycle of the stop sample.
- Reset mid-frame aborts immediately. No pulse is generated and rx_data is cleared.
- donerx and frame_err are never high in the same cycle.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
  - the function baud_div(clk_freq, baud_rate), shared with the transmitter;
  - localparam UART_DATA_BITS = 8.
- One sub-module, uart_sync2: a 2-flop synchroniser with reset value 1, reusable for other asynchronous inputs.

Test Plan:
- Reset with rx=1 -> rx_data=8'h00, donerx=0, frame_err=0, busy=0; no activity for 2000 cycles.
- Defaults, send 8'hA5 at 104 clk/bit -> donerx pulses once, 988+3 clk after the start edge; rx_data=8'hA5.
- Back-to-back 8'h00 then 8'hFF with no idle gap -> two donerx pulses 1040 clk apart; rx_data ends at 8'hFF.
- Start glitch: rx low for 20 clk then high -> busy high about 52 clk, then IDLE; no donerx/frame_err.
- Frame 8'h3C with stop bit forced 0 and line held low 300 clk -> frame_err single pulse, rx_data keeps its previous value, no re-trigger until the line rises; the following 8'h81 is received correctly.
- Assert rst at data bit 4 of 8'h55 -> outputs return to reset values immediately; the next 8'h55 after release is received correctly.
